// File: rtl/rv_div_ctrl_if.sv
// Request/result bundle between the EX-stage control and the iterative divider.
// Signal suffixes are relative to the divider (slave) side.
interface rv_div_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            flush_i;
  logic            ready_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, flush_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, flush_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/rv_div_ctrl.sv
// Restoring radix-2 DIV/DIVU/REM/REMU sequencer, one quotient bit per cycle, XLEN+1 cycle latency.
// Optional RV_DIV_FASTPATH_EN: divide-by-zero, signed overflow and |a|<|b| finish in one cycle.
module rv_div_ctrl #(
  parameter int XLEN = 32
) (
  input logic          clk_i,
  input logic          rst_n_i,
  rv_div_ctrl_if.slave div_if
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            rem_sel_q, rem_sel_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            sgn, a_neg, b_neg, div0;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN+1:0] rem_sh, diff;

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  assign sgn   = ~div_if.op_i[0];
  assign a_neg = sgn & div_if.dividend_i[XLEN-1];
  assign b_neg = sgn & div_if.divisor_i[XLEN-1];
  assign a_mag = neg_if(a_neg, div_if.dividend_i);
  assign b_mag = neg_if(b_neg, div_if.divisor_i);
  assign div0  = (div_if.divisor_i == '0);

`ifdef RV_DIV_FASTPATH_EN
  logic ovf;
  assign ovf = sgn && (div_if.dividend_i == {1'b1, {(XLEN-1){1'b0}}}) &&
               (div_if.divisor_i == '1);
`endif

  // Remainder never exceeds the divisor magnitude, so XLEN+2 bits hold the sign of the trial.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {2'b00, dvsr_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    rem_sel_d = rem_sel_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (div_if.start_i && !div_if.flush_i) begin
          rem_sel_d = div_if.op_i[1];
          negq_d    = (a_neg ^ b_neg) && !div0;
          negr_d    = a_neg;
          rem_d     = '0;
          quo_d     = a_mag;
          dvsr_d    = b_mag;
          cnt_d     = CW'(XLEN);
          state_d   = CALC;
`ifdef RV_DIV_FASTPATH_EN
          if (div0) begin
            quo_d   = '1;
            rem_d   = {1'b0, a_mag};
            cnt_d   = '0;
            state_d = DONE;
          end else if (ovf) begin
            quo_d   = a_mag;
            cnt_d   = '0;
            state_d = DONE;
          end else if (a_mag < b_mag) begin
            quo_d   = '0;
            rem_d   = {1'b0, a_mag};
            cnt_d   = '0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (div_if.flush_i) begin
          state_d = IDLE;
        end else begin
          if (!diff[XLEN+1]) begin
            rem_d = diff[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The result register only moves on the edge that enters DONE.
    if (state_d == DONE && state_q != DONE) begin
      result_d = rem_sel_d ? neg_if(negr_d, rem_d[XLEN-1:0]) : neg_if(negq_d, quo_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      rem_sel_q <= 1'b0;
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      rem_sel_q <= rem_sel_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      result_q  <= result_d;
    end
  end

  assign div_if.ready_o  = (state_q == IDLE);
  assign div_if.valid_o  = (state_q == DONE);
  assign div_if.result_o = result_q;

endmodule

// File: tb/tb_rv_div_ctrl.sv
// Randomized and directed check of rv_div_ctrl against an arithmetic RISC-V division model.
module tb_rv_div_ctrl;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;
`ifdef RV_DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  rv_div_ctrl_if #(.XLEN(XLEN)) dif ();

  rv_div_ctrl #(.XLEN(XLEN)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_res(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [XLEN-1:0] q, r;
    longint sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!op[0]) begin
      if (a == MIN_NEG && b == '1) begin
        q = a;
        r = '0;
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = XLEN'(sa / sb);
        r  = XLEN'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    logic s;
    logic [XLEN-1:0] am, bm;
    bit fast;
    s    = !op[0];
    am   = (s && a[XLEN-1]) ? -a : a;
    bm   = (s && b[XLEN-1]) ? -b : b;
    fast = (b == 0) || (s && a == MIN_NEG && b == '1) || (am < bm);
    return (FAST && fast) ? 1 : XLEN + 1;
  endfunction

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 5))
      0: return $urandom;
      1: return '0;
      2: return '1;
      3: return MIN_NEG;
      4: return XLEN'($urandom_range(0, 20));
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  task automatic drive_req(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    dif.start_i    = 1'b1;
    dif.op_i       = op;
    dif.dividend_i = a;
    dif.divisor_i  = b;
  endtask

  // Issue one request and wait (bounded) for valid; returns at the negedge of the valid cycle.
  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output logic [XLEN-1:0] res, output int lat);
    @(negedge clk);
    drive_req(op, a, b);
    @(negedge clk);
    dif.start_i = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      if (dif.valid_o) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    res = dif.result_o;
  endtask

  task automatic check_op(input string tag, input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    logic [XLEN-1:0] res;
    int lat;
    run_op(op, a, b, res, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(op, a, b)));
    chk({tag, "_res"}, 64'(res), 64'(exp));
    chk({tag, "_rdy_in_done"}, 64'(dif.ready_o), 64'd0);
    @(negedge clk);
    chk({tag, "_vld_pulse"}, 64'(dif.valid_o), 64'd0);
    chk({tag, "_rdy_after"}, 64'(dif.ready_o), 64'd1);
    chk({tag, "_res_held"}, 64'(dif.result_o), 64'(exp));
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [XLEN-1:0] prev;
    logic [1:0]      op;
    logic [XLEN-1:0] a, b;
    bit              seen_vld;

    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    dif.start_i    = 1'b0;
    dif.op_i       = 2'b00;
    dif.dividend_i = '0;
    dif.divisor_i  = '0;
    dif.flush_i    = 1'b0;

    vecs[0] = '{2'b01, 32'd100,        32'd7,          32'd14};
    vecs[1] = '{2'b11, 32'd100,        32'd7,          32'd2};
    vecs[2] = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    vecs[4] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
    vecs[5] = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[6] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0};
    vecs[7] = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF};
    vecs[8] = '{2'b11, 32'd5,          32'd0,          32'd5};
    vecs[9] = '{2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(dif.ready_o), 64'd1);
    chk("rst_valid", 64'(dif.valid_o), 64'd0);
    chk("rst_result", 64'(dif.result_o), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      check_op($sformatf("dir%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Start is ignored while busy, flush aborts without touching the held result.
    prev = dif.result_o;
    @(negedge clk);
    drive_req(2'b01, 32'd1000, 32'd3);
    @(negedge clk);
    dif.start_i = 1'b0;
    seen_vld = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (dif.valid_o) seen_vld = 1'b1;
      if (c == 1) chk("busy_ready", 64'(dif.ready_o), 64'd0);
      if (c == 5) drive_req(2'b01, 32'd50, 32'd5);
      if (c == 6) dif.start_i = 1'b0;
      if (c == 10) dif.flush_i = 1'b1;
      if (c == 11) begin
        dif.flush_i = 1'b0;
        chk("flush_ready", 64'(dif.ready_o), 64'd1);
        chk("flush_valid", 64'(dif.valid_o), 64'd0);
        chk("flush_result", 64'(dif.result_o), 64'(prev));
      end
      @(negedge clk);
    end
    chk("flush_no_valid", 64'(seen_vld), 64'd0);
    chk("flush_result_end", 64'(dif.result_o), 64'(prev));

    // Flush together with start in IDLE drops the request.
    drive_req(2'b01, 32'd40, 32'd4);
    dif.flush_i = 1'b1;
    @(negedge clk);
    dif.start_i = 1'b0;
    dif.flush_i = 1'b0;
    chk("flush_start_ready", 64'(dif.ready_o), 64'd1);

    // Reset mid-operation.
    @(negedge clk);
    drive_req(2'b01, 32'd77, 32'd5);
    @(negedge clk);
    dif.start_i = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c == 20) rst_n = 1'b0;
      if (c == 21) begin
        chk("midrst_ready", 64'(dif.ready_o), 64'd1);
        chk("midrst_valid", 64'(dif.valid_o), 64'd0);
        chk("midrst_result", 64'(dif.result_o), 64'd0);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check_op("post_rst", 2'b01, 32'd9, 32'd3, 32'd3);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      check_op($sformatf("rnd%0d", i), op, a, b, ref_res(op, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
